// File: rtl/mux_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_scan_ctrl_pkg
//  Brief    : Shared state encodings and channel geometry for the mux scanner.
//  Revision : 1.0
// ============================================================================
package mux_scan_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int SEL_W  = 2;
    localparam int NUM_CH = 4;

endpackage
`default_nettype wire

// File: rtl/mux_scan_ctrl_dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mux_scan_ctrl_dwell_timer
//  Brief    : Settle-dwell counter with clear/enable; o_tc flags count DWELL-1.
//  Revision : 1.0
// ============================================================================
module mux_scan_ctrl_dwell_timer #(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int                CNT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            // Wrap at terminal count so a power-of-two DWELL never overflows.
            r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mux_scan_ctrl
//  Brief    : Steps a 4:1 mux through its channels, dwells, samples, and offers
//             the assembled frame on a valid/ready handshake. Optional macro
//             MUX_SCAN_PARITY_EN adds a registered frame_par output.
//  Revision : 1.0
// ============================================================================
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter  int DATA_W  = 4,
    parameter  int DWELL   = 2,
    localparam int FRAME_W = NUM_CH * DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode_cont,
    output logic [SEL_W-1:0]   sel,
    input  logic [DATA_W-1:0]  mux_out,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               busy
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic               frame_par
`endif
);

    localparam logic [SEL_W-1:0] C_LAST_CH = SEL_W'(NUM_CH - 1);

    logic [1:0]         r_state;
    logic [SEL_W-1:0]   r_ch;
    logic [SEL_W-1:0]   r_sel;
    logic [FRAME_W-1:0] r_frame;
    logic               r_frame_valid;
    logic [FRAME_W-1:0] w_frame_next;
    logic               w_tc;
    logic               w_in_settle;

    assign w_in_settle = (r_state == ST_SETTLE);

    mux_scan_ctrl_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .i_clr (!w_in_settle),
        .i_en  (w_in_settle),
        .o_tc  (w_tc)
    );

    always_comb begin
        w_frame_next = r_frame;
        w_frame_next[r_ch*DATA_W +: DATA_W] = mux_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ch          <= '0;
            r_sel         <= '0;
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SETTLE;
                        r_ch    <= '0;
                        r_sel   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (w_tc) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_frame <= w_frame_next;
                    if (r_ch == C_LAST_CH) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_sel   <= r_ch + 1'b1;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    // frame_valid trails DONE entry by one cycle; ready is ignored until it is up.
                    if (!r_frame_valid) begin
                        r_frame_valid <= 1'b1;
                    end else if (frame_ready) begin
                        r_frame_valid <= 1'b0;
                        if (mode_cont) begin
                            r_state <= ST_SETTLE;
                            r_ch    <= '0;
                            r_sel   <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic r_frame_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_par <= 1'b0;
        end else if (r_state == ST_SAMPLE) begin
            r_frame_par <= ^w_frame_next;
        end
    end

    assign frame_par = r_frame_par;
`endif

    assign sel         = r_sel;
    assign frame       = r_frame;
    assign frame_valid = r_frame_valid;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_scan_ctrl
//  Brief    : Directed self-checking bench for mux_scan_ctrl with a 4:1 mux model.
//  Revision : 1.0
// ============================================================================
module tb_mux_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode_cont;
    logic [1:0]  sel;
    logic [3:0]  mux_out;
    logic [15:0] frame;
    logic        frame_valid;
    logic        frame_ready;
    logic        busy;
    logic [3:0]  a, b, c, d;
`ifdef MUX_SCAN_PARITY_EN
    logic        frame_par;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            2'd0:    mux_out = a;
            2'd1:    mux_out = b;
            2'd2:    mux_out = c;
            default: mux_out = d;
        endcase
    end

    mux_scan_ctrl #(
        .DATA_W (4),
        .DWELL  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode_cont   (mode_cont),
        .sel         (sel),
        .mux_out     (mux_out),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .frame_par   (frame_par)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mode_cont = 1'b0; frame_ready = 1'b0;
        a = 4'h5; b = 4'h6; c = 4'h7; d = 4'h8;
        tick(); tick();
        chk("rst_sel",   16'(sel), 16'h0);
        chk("rst_frame", frame, 16'h0);
        chk("rst_valid", 16'(frame_valid), 16'h0);
        chk("rst_busy",  16'(busy), 16'h0);
`ifdef MUX_SCAN_PARITY_EN
        chk("rst_par",   16'(frame_par), 16'h0);
`endif
        rst = 1'b0;

        // Single shot, ready held high throughout
        frame_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        chk("t1_busy_start", 16'(busy), 16'h1);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("t1_sel_step", 16'(sel), 16'((i / 3 > 3) ? 3 : i / 3));
            chk("t1_valid_low", 16'(frame_valid), 16'h0);
        end
        tick();
        chk("t1_valid_k13", 16'(frame_valid), 16'h1);
        chk("t1_frame",     frame, 16'h8765);
        chk("t1_sel_done",  16'(sel), 16'h3);
        tick();
        chk("t1_valid_drop", 16'(frame_valid), 16'h0);
        chk("t1_busy_idle",  16'(busy), 16'h0);

        // Backpressure
        frame_ready = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        repeat (12) tick();
        chk("t2_valid_k12", 16'(frame_valid), 16'h0);
        tick();
        chk("t2_valid_k13", 16'(frame_valid), 16'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_hold_valid", 16'(frame_valid), 16'h1);
            chk("t2_hold_frame", frame, 16'h8765);
            chk("t2_hold_sel",   16'(sel), 16'h3);
        end
        frame_ready = 1'b1;
        tick();
        chk("t2_valid_drop", 16'(frame_valid), 16'h0);
        chk("t2_busy_idle",  16'(busy), 16'h0);

        // Continuous re-scan, channel A changes after its first sample
        mode_cont = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        repeat (5) tick();
        a = 4'hA;
        repeat (7) tick();
        chk("t3_valid_k12", 16'(frame_valid), 16'h0);
        tick();
        chk("t3_valid_f1", 16'(frame_valid), 16'h1);
        chk("t3_frame_f1", frame, 16'h8765);
        tick();
        chk("t3_valid_hs", 16'(frame_valid), 16'h0);
        chk("t3_busy_hs",  16'(busy), 16'h1);
        chk("t3_sel_rescan", 16'(sel), 16'h0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("t3_busy_gap", 16'(busy), 16'h1);
        end
        mode_cont = 1'b0;
        tick();
        chk("t3_valid_f2", 16'(frame_valid), 16'h1);
        chk("t3_frame_f2", frame, 16'h876A);
        tick();
        chk("t3_busy_stop",  16'(busy), 16'h0);
        chk("t3_frame_keep", frame, 16'h876A);
        a = 4'h5;

        // Reset during channel 2 settle
        start = 1'b1;
        tick(); start = 1'b0;
        repeat (6) tick();
        chk("t4_sel_ch2", 16'(sel), 16'h2);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("t4_rst_sel",   16'(sel), 16'h0);
        chk("t4_rst_frame", frame, 16'h0);
        chk("t4_rst_valid", 16'(frame_valid), 16'h0);
        chk("t4_rst_busy",  16'(busy), 16'h0);
        start = 1'b1;
        tick(); start = 1'b0;
        repeat (13) tick();
        chk("t4_valid", 16'(frame_valid), 16'h1);
        chk("t4_frame", frame, 16'h8765);
        tick();
        chk("t4_busy_idle", 16'(busy), 16'h0);

        // Extra start pulses while busy
        start = 1'b1;
        tick(); start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick(); start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick(); start = 1'b0;
        repeat (4) tick();
        chk("t5_valid_k12", 16'(frame_valid), 16'h0);
        tick();
        chk("t5_valid_k13", 16'(frame_valid), 16'h1);
        chk("t5_frame",     frame, 16'h8765);
`ifdef MUX_SCAN_PARITY_EN
        chk("t6_parity",    16'(frame_par), 16'h0);
`endif
        tick();
        chk("t5_busy_idle", 16'(busy), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
